// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, bus FSM states, the machine-timer
// interrupt cause, and the byte-merge used for register writes with strobes.
package clint_pkg;

  localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] MTIME_OFS    = 16'hBFF8;
  localparam logic [63:0] MCAUSE_MTI   = 64'h8000_0000_0000_0007;

  typedef enum logic {
    IDLE,
    RESP
  } bus_state_e;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Prescaler for mtime: div_cnt runs 0..TICK_DIV-1 and tick marks its last count.
// With TICK_DIV=1 the counter stays at 0 and tick is permanently high.
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick = (div_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a single-outstanding MMIO port,
// with a registered level interrupt raised while mtime >= mtimecmp.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_req_valid_i,
  output logic        mmio_req_ready_o,
  input  logic        mmio_req_we_i,
  input  logic [63:0] mmio_req_addr_i,
  input  logic [63:0] mmio_req_wdata_i,
  input  logic [7:0]  mmio_req_wstrb_i,
  output logic        mmio_rsp_valid_o,
  input  logic        mmio_rsp_ready_i,
  output logic [63:0] mmio_rsp_rdata_o,
  output logic        mmio_rsp_err_o,
  output logic        timer_int_o
);

  localparam logic [63:0] DW_MASK       = ~64'h7;
  localparam logic [63:0] MTIMECMP_ADDR = (BASE_ADDR + {48'd0, MTIMECMP_OFS}) & DW_MASK;
  localparam logic [63:0] MTIME_ADDR    = (BASE_ADDR + {48'd0, MTIME_OFS}) & DW_MASK;

  bus_state_e  state, state_nxt;
  logic        tick;
  logic [63:0] mtime, mtimecmp;
  logic [63:0] addr_dw;
  logic [63:0] rd_sel;
  logic        hit_mtime, hit_cmp, accept;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign addr_dw   = mmio_req_addr_i & DW_MASK;
  assign hit_mtime = (addr_dw == MTIME_ADDR);
  assign hit_cmp   = (addr_dw == MTIMECMP_ADDR);
  assign accept    = mmio_req_valid_i && mmio_req_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    mmio_req_ready_o = 1'b0;
    mmio_rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        mmio_req_ready_o = 1'b1;
        if (mmio_req_valid_i) state_nxt = RESP;
      end
      RESP: begin
        mmio_rsp_valid_o = 1'b1;
        if (mmio_rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A write that lands on a tick edge replaces the increment entirely; the
  // unwritten bytes keep the pre-increment value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       mtime <= '0;
    else if (accept && mmio_req_we_i && hit_mtime) mtime <= merge_bytes(mtime, mmio_req_wdata_i, mmio_req_wstrb_i);
    else if (tick)                                 mtime <= mtime + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     mtimecmp <= '1;
    else if (accept && mmio_req_we_i && hit_cmp) mtimecmp <= merge_bytes(mtimecmp, mmio_req_wdata_i, mmio_req_wstrb_i);
  end

  always_comb begin
    rd_sel = '0;
    if (!mmio_req_we_i) begin
      if (hit_mtime)    rd_sel = mtime;
      else if (hit_cmp) rd_sel = mtimecmp;
    end
  end

  // Response is captured at acceptance and held until the LSU consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_rsp_rdata_o <= '0;
      mmio_rsp_err_o   <= 1'b0;
    end else if (accept) begin
      mmio_rsp_rdata_o <= rd_sel;
      mmio_rsp_err_o   <= !(hit_mtime || hit_cmp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_int_o <= 1'b0;
    else     timer_int_o <= (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance with TICK_DIV=1 (dut 0) and one
// with TICK_DIV=4 (dut 1), sharing clock and reset.
module tb_clint_timer;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, tint;
  logic        req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [63:0] rdata0, rdata1;

  int checks, errors;
  int ecnt;

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .mmio_req_valid_i(req_valid[0]), .mmio_req_ready_o(req_ready[0]),
    .mmio_req_we_i(req_we), .mmio_req_addr_i(req_addr),
    .mmio_req_wdata_i(req_wdata), .mmio_req_wstrb_i(req_wstrb),
    .mmio_rsp_valid_o(rsp_valid[0]), .mmio_rsp_ready_i(rsp_ready[0]),
    .mmio_rsp_rdata_o(rdata0), .mmio_rsp_err_o(rsp_err[0]),
    .timer_int_o(tint[0])
  );

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst),
    .mmio_req_valid_i(req_valid[1]), .mmio_req_ready_o(req_ready[1]),
    .mmio_req_we_i(req_we), .mmio_req_addr_i(req_addr),
    .mmio_req_wdata_i(req_wdata), .mmio_req_wstrb_i(req_wstrb),
    .mmio_rsp_valid_o(rsp_valid[1]), .mmio_rsp_ready_i(rsp_ready[1]),
    .mmio_rsp_rdata_o(rdata1), .mmio_rsp_err_o(rsp_err[1]),
    .timer_int_o(tint[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: edge 1 is the first rising edge after reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  // Called with clk low. One full request/response; hold keeps rsp_ready low
  // for that many cycles while the response is checked for stability.
  task automatic bus(input int d, input logic we, input logic [63:0] addr,
                     input logic [63:0] wd, input logic [7:0] strb, input int hold,
                     output logic [63:0] rd, output logic er, output int acc,
                     output logic ti_acc, output logic ti_nxt);
    int n;
    logic [63:0] cur;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL bus_ready dut%0d: req_ready=%b required 1 within 20 cycles", d, req_ready[d]);
    end
    req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    acc = ecnt;
    rd = d ? rdata1 : rdata0;
    er = rsp_err[d];
    ti_acc = tint[d];
    checks++;
    if (rsp_valid[d] !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid_rise dut%0d: got %b required 1", d, rsp_valid[d]);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      cur = d ? rdata1 : rdata0;
      checks++;
      if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || cur !== rd || rsp_err[d] !== er) begin
        errors++;
        $display("FAIL rsp_hold dut%0d cyc%0d: valid=%b ready=%b rdata=%h err=%b required 1 0 %h %b",
                 d, i, rsp_valid[d], req_ready[d], cur, rsp_err[d], rd, er);
      end
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    ti_nxt = tint[d];
    checks++;
    if (rsp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL rsp_valid_fall dut%0d: got %b required 0", d, rsp_valid[d]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL rst_req_ready dut%0d: got %b required 1", d, req_ready[d]); end
      checks++;
      if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid dut%0d: got %b required 0", d, rsp_valid[d]); end
      checks++;
      if ((d ? rdata1 : rdata0) !== 64'd0) begin errors++; $display("FAIL rst_rdata dut%0d: got %h required 0", d, d ? rdata1 : rdata0); end
      checks++;
      if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL rst_err dut%0d: got %b required 0", d, rsp_err[d]); end
      checks++;
      if (tint[d] !== 1'b0) begin errors++; $display("FAIL rst_tint dut%0d: got %b required 0", d, tint[d]); end
    end
  endtask

  task automatic test_idle_read();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    wait_neg(10);
    bus(0, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'(acc - 1) || er !== 1'b0) begin errors++; $display("FAIL idle_mtime: rdata=%h err=%b required %h 0", rd, er, 64'(acc - 1)); end
    checks++;
    if (tint[0] !== 1'b0) begin errors++; $display("FAIL idle_tint: got %b required 0", tint[0]); end
    bus(0, 1'b0, A_TIME | 64'h7, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'(acc - 1) || er !== 1'b0) begin errors++; $display("FAIL lowbits_mtime: rdata=%h err=%b required %h 0", rd, er, 64'(acc - 1)); end
    bus(0, 1'b0, A_CMP, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== ALL1 || er !== 1'b0) begin errors++; $display("FAIL rst_mtimecmp: rdata=%h err=%b required %h 0", rd, er, ALL1); end
  endtask

  task automatic test_compare();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    wait_neg(4);
    bus(0, 1'b1, A_CMP, 64'd20, 8'hFF, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd0 || er !== 1'b0) begin errors++; $display("FAIL write_rsp: rdata=%h err=%b required 0 0", rd, er); end
    wait_neg(20);
    checks++;
    if (tint[0] !== 1'b0) begin errors++; $display("FAIL tint_edge20: got %b required 0", tint[0]); end
    wait_neg(21);
    checks++;
    if (tint[0] !== 1'b1) begin errors++; $display("FAIL tint_edge21: got %b required 1", tint[0]); end
    bus(0, 1'b1, A_CMP, 64'd1000, 8'hFF, 0, rd, er, acc, ta, tn);
    checks++;
    if (ta !== 1'b1 || tn !== 1'b0) begin errors++; $display("FAIL tint_clear: at_acc=%b next=%b required 1 0", ta, tn); end
    bus(0, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'(acc - 1)) begin errors++; $display("FAIL cmp_write_mtime: got %h required %h", rd, 64'(acc - 1)); end
  endtask

  task automatic test_prescaler();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    wait_neg(3);
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd0) begin errors++; $display("FAIL div4_edge4: got %h required 0", rd); end
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd1) begin errors++; $display("FAIL div4_edge6: got %h required 1", rd); end
    wait_neg(11);
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd2) begin errors++; $display("FAIL div4_edge12: got %h required 2", rd); end
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd3) begin errors++; $display("FAIL div4_edge14: got %h required 3", rd); end
  endtask

  task automatic test_wrap();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    wait_neg(15);
    bus(1, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, rd, er, acc, ta, tn);
    wait_neg(20);
    checks++;
    if (tint[1] !== 1'b0) begin errors++; $display("FAIL wrap_tint20: got %b required 0", tint[1]); end
    wait_neg(21);
    checks++;
    if (tint[1] !== 1'b1) begin errors++; $display("FAIL wrap_tint21: got %b required 1", tint[1]); end
    wait_neg(24);
    checks++;
    if (tint[1] !== 1'b1) begin errors++; $display("FAIL wrap_tint24: got %b required 1", tint[1]); end
    wait_neg(25);
    checks++;
    if (tint[1] !== 1'b0) begin errors++; $display("FAIL wrap_tint25: got %b required 0", tint[1]); end
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd0) begin errors++; $display("FAIL wrap_mtime: got %h required 0", rd); end
  endtask

  task automatic test_tick_collision();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    wait_neg(3);
    bus(1, 1'b1, A_TIME, 64'h0000_0001_FFFF_FFFF, 8'hFF, 0, rd, er, acc, ta, tn);
    wait_neg(7);
    bus(1, 1'b1, A_TIME, 64'hAAAA_AAAA_1234_5678, 8'h0F, 0, rd, er, acc, ta, tn);
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'h0000_0001_1234_5678) begin errors++; $display("FAIL partial_write: got %h required 0000000112345678", rd); end
    wait_neg(13);
    bus(1, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'h0000_0001_1234_5679) begin errors++; $display("FAIL post_collision_tick: got %h required 0000000112345679", rd); end
  endtask

  task automatic test_miss();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    bus(0, 1'b0, A_CMP, '0, '0, 0, rd, er, acc, ta, tn);
    bus(0, 1'b0, BASE + 64'h100, '0, '0, 5, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'd0 || er !== 1'b1) begin errors++; $display("FAIL miss_read: rdata=%h err=%b required 0 1", rd, er); end
    bus(0, 1'b1, BASE + 64'h100, 64'd7, 8'hFF, 0, rd, er, acc, ta, tn);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL miss_write_err: got %b required 1", er); end
    bus(0, 1'b0, A_CMP, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== ALL1 || er !== 1'b0) begin errors++; $display("FAIL miss_cmp_kept: rdata=%h err=%b required %h 0", rd, er, ALL1); end
    bus(0, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== 64'(acc - 1)) begin errors++; $display("FAIL miss_mtime_kept: got %h required %h", rd, 64'(acc - 1)); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er, ta, tn; int acc;
    do_reset();
    bus(0, 1'b1, A_CMP, 64'd5, 8'hFF, 0, rd, er, acc, ta, tn);
    wait_neg(8);
    checks++;
    if (tint[0] !== 1'b1) begin errors++; $display("FAIL pre_rst_tint: got %b required 1", tint[0]); end
    req_we = 1'b0; req_addr = A_CMP; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL mid_rsp_valid: got %b required 1", rsp_valid[0]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || tint[0] !== 1'b0 || rdata0 !== 64'd0 || rsp_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: valid=%b ready=%b tint=%b rdata=%h err=%b required 0 1 0 0 0",
               rsp_valid[0], req_ready[0], tint[0], rdata0, rsp_err[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    bus(0, 1'b0, A_TIME, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (acc !== 1 || rd !== 64'd0) begin errors++; $display("FAIL post_rst_first: accepted at edge %0d rdata=%h required edge 1 rdata 0", acc, rd); end
    bus(0, 1'b0, A_CMP, '0, '0, 0, rd, er, acc, ta, tn);
    checks++;
    if (rd !== ALL1) begin errors++; $display("FAIL post_rst_cmp: got %h required %h", rd, ALL1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle_read();
    test_compare();
    test_prescaler();
    test_wrap();
    test_tick_collision();
    test_miss();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer feeding the core-local interruptor's `timer_int_i`. Holds the 64-bit `mtime` counter, advanced by a programmable prescaler, and the `mtimecmp` compare register. Both are reachable over a single-outstanding MMIO request/response port driven by the LSU. Raises a level timer-interrupt request whenever `mtime >= mtimecmp`.

## Interface
Parameters:
- `BASE_ADDR`, default `64'h0000_0000_0200_0000`: CLINT base. `mtimecmp` sits at `BASE_ADDR+0x4000`, `mtime` at `BASE_ADDR+0xBFF8`.
- `TICK_DIV`, default `1`: core clocks per `mtime` increment. Legal range is ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mmio_req_valid_i` in 1: request valid.
- `mmio_req_ready_o` out 1: request accepted when valid&ready.
- `mmio_req_we_i` in 1: 1 = write, 0 = read.
- `mmio_req_addr_i` in 64: byte address. Bits [2:0] are ignored; the access is doubleword-aligned.
- `mmio_req_wdata_i` in 64: write data.
- `mmio_req_wstrb_i` in 8: byte enables for writes.
- `mmio_rsp_valid_o` out 1: response valid.
- `mmio_rsp_ready_i` in 1: response consumed when valid&ready.
- `mmio_rsp_rdata_o` out 64: read data. Forced to 0 on writes and errors.
- `mmio_rsp_err_o` out 1: address matched neither register.
- `timer_int_o` out 1: level interrupt request, to the CLINT `timer_int_i`.

## Operation
- Prescaler `div_cnt` counts 0..TICK_DIV-1 and wraps to 0.
- `tick` = (`div_cnt == TICK_DIV-1`). When `tick` is high, `mtime` increments by 1. It wraps from 2^64-1 to 0.
- When TICK_DIV=1, `tick` is constantly 1.
- Bus FSM has two states:
  - IDLE: `mmio_req_ready_o=1`. On handshake, perform the access and go to RESP.
  - RESP: `mmio_req_ready_o=0`, `mmio_rsp_valid_o=1`. On `mmio_rsp_ready_i`, go to IDLE.
- There is no back-to-back acceptance: at most one request per two cycles.
- Write: for each set `wstrb[i]`, byte i of the target register takes `wdata` byte i. Unset bytes keep their value.
- Partial writes to `mtime` merge against the pre-increment value.
- Read: `rdata` captures the target register's value in the acceptance cycle, i.e. the value before that edge's update.
- Address miss: no register changes; the response carries `err=1` and `rdata=0`. A miss does not hang the FSM.
- Simultaneous `mtime` write and `tick`: the write wins. Written bytes take `wdata`; unwritten bytes take the old, un-incremented bytes, so the increment is dropped. `div_cnt` still advances.
- `mtimecmp` writes never affect `mtime` or `div_cnt`.
- Interrupt: `timer_int_o` is the registered value of (`mtime >= mtimecmp`), an unsigned compare of the current register values. It stays high until software raises `mtimecmp` or `mtime` wraps.
- Reset values: `mtime=0`, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF` (no spurious interrupt), `div_cnt=0`, FSM=IDLE, `mmio_req_ready_o=1`, `mmio_rsp_valid_o=0`, `mmio_rsp_rdata_o=0`, `mmio_rsp_err_o=0`, `timer_int_o=0`.
- Reset asserted mid-transaction aborts it immediately. Any pending response is dropped, and `rsp_valid` falls asynchronously.

## Timing
- Request accepted at edge N. Register write is visible from N+1. `rsp_valid` is high from N+1 and held, with stable `rdata`/`err`, until `rsp_ready` is sampled high.
- Earliest next acceptance is the edge after the response handshake.
- `mtime` increments at edges where `tick` was 1 in the preceding cycle. With TICK_DIV=k, the first increment after reset is at edge k.
- Interrupt latency: `timer_int_o` rises one edge after the edge at which `mtime >= mtimecmp` first holds in the registers.
- Interrupt deassertion after a `mtimecmp` write accepted at edge N: `timer_int_o` falls at edge N+1.
- No combinational path from any input to any output except `mmio_req_ready_o`, which is a function of FSM state only.

## Structure
- Shared package `clint_pkg`:
  - offset constants `MTIMECMP_OFS=16'h4000`, `MTIME_OFS=16'hBFF8`
  - FSM state enum {IDLE, RESP}
  - `MCAUSE_MTI=64'h8000_0000_0000_0007`, shared with the interruptor
- One sub-module, `clint_prescaler` (the `div_cnt` plus `tick` generator), parameterised by TICK_DIV.
- Everything else is flat in `clint_timer`.

## Test plan
- Reset then idle 10 cycles, TICK_DIV=1 → read `mtime` returns 10 ±1 (exact value checked against the model); `timer_int_o=0`; read `mtimecmp` returns `64'hFFFF_FFFF_FFFF_FFFF`.
- Write `mtimecmp=20` with wstrb=`8'hFF` at cycle 5 → `timer_int_o` rises exactly one edge after `mtime` reaches 20. Then write `mtimecmp=1000` → `timer_int_o` falls at the next edge.
- TICK_DIV=4 → `mtime` increments at edges 4, 8, 12. Then write `mtime=64'hFFFF_FFFF_FFFF_FFFE` → wraps to 0 after 8 cycles; `timer_int_o` drops after the wrap when `mtimecmp` > 0.
- Write `mtime` with wstrb=`8'h0F`, wdata=`64'hAAAA_AAAA_1234_5678`, timed coincident with a `tick` → low word becomes `0x12345678`, high word is unchanged, and no increment is applied that edge.
- Read at `BASE_ADDR+0x100` → `rsp_err=1`, `rdata=0`, no register changes. Hold `rsp_ready=0` for 5 cycles → response stays stable and `req_ready` stays 0.
- Assert `rst` in the RESP state → `rsp_valid` drops immediately and all registers return to their reset values. After release, a new request is accepted on the first cycle.
